reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- General-purpose integer register file for the BRISC-V RV32I core, instantiated inside the decode stage.
- Provides 2^ADDR_WIDTH registers of DATA_WIDTH bits, with two combinational read ports and one synchronous write port.
- Register 0 is hardwired to zero (RISC-V x0 semantics).
- Write-to-read forwarding within the same cycle is handled outside this block by the decode stage.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, width of the select ports; register count = 2^ADDR_WIDTH (32 by default).

Ports:
- clock  input  1  core clock; all writes occur on its rising edge.
- reset  input  1  asynchronous, active-low reset; clears every register to 0.
- read_sel1  input  ADDR_WIDTH  register index for read port 1 (rs1).
- read_sel2  input  ADDR_WIDTH  register index for read port 2 (rs2).
- wEn  input  1  write enable, active-high.
- write_sel  input  ADDR_WIDTH  destination register index (rd).
- write_data  input  DATA_WIDTH  value to write.
- read_data1  output  DATA_WIDTH  contents of the register selected by read_sel1.
- read_data2  output  DATA_WIDTH  contents of the register selected by read_sel2.

Behaviour:
- Storage: 2^ADDR_WIDTH x DATA_WIDTH array of flip-flops.
- Reset:
  - reset=0 asynchronously forces every register to 0, regardless of clock.
  - Reset has priority over any write in progress.
  - While reset is held low, both outputs read 0.
- Write:
  - On posedge clock with reset=1 and wEn=1, register[write_sel] <= write_data.
  - The write is ignored when write_sel == 0.
  - wEn=0 means no state change.
- Read:
  - Purely combinational, zero latency: read_dataN = register[read_selN].
  - read_selN == 0 always returns 0.
- No internal bypass: a read of the register being written in the same cycle returns the OLD value. The new value is visible immediately after the rising edge; the decode stage supplies forwarding.
- Both read ports are independent and may select the same register (including write_sel) simultaneously.
- Register 0 is never written; its storage may be omitted or held at 0.
- Synthesisable; no latches; no X on outputs after reset.

Test Plan:
- Reset: write 0xDEADBEEF to x5, then pulse reset low mid-cycle (asynchronous, between clock edges) -> read_data1 (sel=5) becomes 0 immediately, without waiting for a clock edge.
- Basic write/read: wEn=1, write_sel=7, write_data=0x12345678, one clock edge; then read_sel1=7, read_sel2=7 -> both outputs 0x12345678.
- x0 immutability: wEn=1, write_sel=0, write_data=0xFFFFFFFF, one clock edge -> read_sel1=0 returns 0x00000000.
- Write-enable gating: x3 = 0x11; apply wEn=0, write_sel=3, write_data=0x22, one clock edge -> x3 still reads 0x11.
- Same-cycle read of written register: x9 = 0xA; drive read_sel1=9, wEn=1, write_sel=9, write_data=0xB -> read_data1=0xA before the edge and 0xB after the edge.
- Full sweep: write value (i*0x01010101) to x1..x31, then read all pairs (i, 31-i) on the two ports -> each output matches its written value and x0 reads 0.

Source files
------------

// File: rtl/reg_file.sv
// reg_file: RV32I general-purpose integer register file.
// 2^ADDR_WIDTH registers of DATA_WIDTH bits, two combinational read ports and
// one synchronous write port. Register 0 reads as zero and is never stored.
// There is no write-to-read bypass; the decode stage forwards in-flight writes.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_sel1,
  input  logic [ADDR_WIDTH-1:0] read_sel2,
  input  logic                  wEn,
  input  logic [ADDR_WIDTH-1:0] write_sel,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  // Storage starts at index 1: x0 has no flip-flops and is synthesised as 0.
  logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] rd1_s;
  logic [DATA_WIDTH-1:0] rd2_s;

  // Next-state: only the addressed non-zero register takes write_data.
  always_comb begin
    for (int i = 1; i < NUM_REGS; i++) begin
      if (wEn && (write_sel == ADDR_WIDTH'(i))) begin
        regs_d[i] = write_data;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Register array; the asynchronous active-low reset overrides any write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read port 1 mux: select 0 falls through to the zero default.
  always_comb begin
    rd1_s = {DATA_WIDTH{1'b0}};
    for (int i = 1; i < NUM_REGS; i++) begin
      if (read_sel1 == ADDR_WIDTH'(i)) begin
        rd1_s = regs_q[i];
      end else begin
        rd1_s = rd1_s;
      end
    end
  end

  // Read port 2 mux: independent of port 1, same zero-default behaviour.
  always_comb begin
    rd2_s = {DATA_WIDTH{1'b0}};
    for (int i = 1; i < NUM_REGS; i++) begin
      if (read_sel2 == ADDR_WIDTH'(i)) begin
        rd2_s = regs_q[i];
      end else begin
        rd2_s = rd2_s;
      end
    end
  end

  // Reads are zero-latency, so the outputs are driven straight from the muxes.
  assign read_data1 = rd1_s;
  assign read_data2 = rd2_s;

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed and randomized checks of reg_file against an array model.
module tb_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clock;
  logic          reset;
  logic [AW-1:0] read_sel1;
  logic [AW-1:0] read_sel2;
  logic          wEn;
  logic [AW-1:0] write_sel;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data1;
  logic [DW-1:0] read_data2;

  logic [DW-1:0] model [32];
  int checks;
  int failures;

  reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .read_sel1  (read_sel1),
    .read_sel2  (read_sel2),
    .wEn        (wEn),
    .write_sel  (write_sel),
    .write_data (write_data),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; update the model with what a register file does.
  task automatic tick();
    @(posedge clock);
    if (reset && wEn && (write_sel != 5'd0)) model[write_sel] = write_data;
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  task automatic write_reg(input logic [AW-1:0] sel, input logic [DW-1:0] data);
    wEn = 1'b1; write_sel = sel; write_data = data;
    tick();
    wEn = 1'b0;
  endtask

  task automatic check_reads(input string tag);
    #1;
    chk({tag, "_rd1"}, read_data1, model[read_sel1]);
    chk({tag, "_rd2"}, read_data2, model[read_sel2]);
  endtask

  initial begin
    checks = 0; failures = 0;
    clear_model();
    reset = 1'b0; wEn = 1'b0; write_sel = 5'd0; write_data = 32'd0;
    read_sel1 = 5'd1; read_sel2 = 5'd31;
    #12;
    check_reads("reset_state");
    reset = 1'b1;
    tick();
    check_reads("after_release");

    // Asynchronous reset between clock edges.
    write_reg(5'd5, 32'hDEADBEEF);
    read_sel1 = 5'd5; read_sel2 = 5'd5;
    #1;
    chk("pre_reset_x5", read_data1, 32'hDEADBEEF);
    #1;
    reset = 1'b0;
    clear_model();
    #1;
    chk("async_reset_x5", read_data1, 32'd0);
    // Write attempted while reset is held must not land.
    wEn = 1'b1; write_sel = 5'd5; write_data = 32'h55AA55AA;
    tick();
    wEn = 1'b0;
    chk("reset_priority_x5", read_data1, 32'd0);
    #2;
    reset = 1'b1;
    tick();

    // Basic write/read on both ports.
    write_reg(5'd7, 32'h12345678);
    read_sel1 = 5'd7; read_sel2 = 5'd7;
    #1;
    chk("basic_rd1", read_data1, 32'h12345678);
    chk("basic_rd2", read_data2, 32'h12345678);

    // x0 immutability.
    write_reg(5'd0, 32'hFFFFFFFF);
    read_sel1 = 5'd0; read_sel2 = 5'd0;
    #1;
    chk("x0_rd1", read_data1, 32'd0);
    chk("x0_rd2", read_data2, 32'd0);

    // Write-enable gating.
    write_reg(5'd3, 32'h11);
    wEn = 1'b0; write_sel = 5'd3; write_data = 32'h22;
    tick();
    read_sel1 = 5'd3;
    #1;
    chk("wen_gate_x3", read_data1, 32'h11);

    // Same-cycle read of the register being written returns the old value.
    write_reg(5'd9, 32'hA);
    read_sel1 = 5'd9; read_sel2 = 5'd9;
    wEn = 1'b1; write_sel = 5'd9; write_data = 32'hB;
    #1;
    chk("same_cycle_old", read_data1, 32'hA);
    tick();
    chk("same_cycle_new_rd1", read_data1, 32'hB);
    chk("same_cycle_new_rd2", read_data2, 32'hB);
    wEn = 1'b0;

    // Full sweep: x_i = i * 0x01010101, read pairs (i, 31-i).
    for (int i = 1; i < 32; i++) write_reg(AW'(i), 32'h01010101 * i);
    for (int i = 0; i < 32; i++) begin
      read_sel1 = AW'(i); read_sel2 = AW'(31 - i);
      #1;
      chk("sweep_rd1", read_data1, (i == 0) ? 32'd0 : 32'h01010101 * i);
      chk("sweep_rd2", read_data2, (i == 31) ? 32'd0 : 32'h01010101 * (31 - i));
    end

    // Randomized traffic against the model, checking before each edge.
    for (int n = 0; n < 400; n++) begin
      wEn        = 1'($urandom_range(0, 3) != 0);
      write_sel  = AW'($urandom);
      write_data = $urandom;
      read_sel1  = AW'($urandom);
      read_sel2  = ($urandom_range(0, 3) == 0) ? write_sel : AW'($urandom);
      check_reads("random");
      tick();
    end
    wEn = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
